// File: rtl/wb_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_redirect_ctrl_pkg
// Purpose  : Shared encodings for the writeback redirect controller: PC-mux
//            select codes, machine-mode mcause values, FSM state codes and
//            the trap-classification record produced by wb_trap_prio.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package wb_redirect_ctrl_pkg;

  // Fetch PC-mux select
  localparam logic [1:0] PCM_SEQ  = 2'b00;
  localparam logic [1:0] PCM_BR   = 2'b01;
  localparam logic [1:0] PCM_TRAP = 2'b10;
  localparam logic [1:0] PCM_MRET = 2'b11;

  // mcause exception codes (interrupt bit is always 0 here)
  localparam logic [3:0] CAUSE_IAM     = 4'd0;
  localparam logic [3:0] CAUSE_IAF     = 4'd1;
  localparam logic [3:0] CAUSE_II      = 4'd2;
  localparam logic [3:0] CAUSE_BKPT    = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

  // Redirect FSM
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_FLUSHING = 2'd2;

  // Result of trap classification. mtval_addr selects a faulting address
  // for mtval (fetch-side faults) instead of zero.
  typedef struct packed {
    logic       is_trap;
    logic [3:0] cause;
    logic       mtval_addr;
  } trap_info_t;

endpackage
`default_nettype wire

// File: rtl/wb_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_redirect_ctrl_if
// Purpose  : Bundle of retiring-instruction status, CSR inputs, and the
//            redirect / trap-CSR outputs of wb_redirect_ctrl.
// Modports : master - writeback/CSR side driving status, observing redirect
//            slave  - the redirect controller
// Revision : 1.0 - initial release
// ============================================================================
interface wb_redirect_ctrl_if #(
  parameter int XLEN = 64
);
  logic            WB_VALID;
  logic [XLEN-1:0] WB_PC;
  logic            WB_BR_TAKEN;
  logic [XLEN-1:0] WB_BR_TARGET;
  logic            WB_IAM;
  logic            WB_IAF;
  logic            WB_II;
  logic            WB_ECALL;
  logic            WB_EBREAK;
  logic            WB_MRET;
  logic [XLEN-1:0] DE_MTVEC;
  logic [XLEN-1:0] CSR_MEPC;
  logic [1:0]      WB_PC_MUX;
  logic [XLEN-1:0] WB_BR_JMP_PC;
  logic            FLUSH;
  logic            CSR_TRAP_WE;
  logic [XLEN-1:0] CSR_MEPC_WD;
  logic [XLEN-1:0] CSR_MCAUSE_WD;
  logic [XLEN-1:0] CSR_MTVAL_WD;

  modport master (
    output WB_VALID, WB_PC, WB_BR_TAKEN, WB_BR_TARGET, WB_IAM, WB_IAF,
           WB_II, WB_ECALL, WB_EBREAK, WB_MRET, DE_MTVEC, CSR_MEPC,
    input  WB_PC_MUX, WB_BR_JMP_PC, FLUSH, CSR_TRAP_WE, CSR_MEPC_WD,
           CSR_MCAUSE_WD, CSR_MTVAL_WD
  );

  modport slave (
    input  WB_VALID, WB_PC, WB_BR_TAKEN, WB_BR_TARGET, WB_IAM, WB_IAF,
           WB_II, WB_ECALL, WB_EBREAK, WB_MRET, DE_MTVEC, CSR_MEPC,
    output WB_PC_MUX, WB_BR_JMP_PC, FLUSH, CSR_TRAP_WE, CSR_MEPC_WD,
           CSR_MCAUSE_WD, CSR_MTVAL_WD
  );
endinterface
`default_nettype wire

// File: rtl/wb_redirect_ctrl_prio.sv
`default_nettype none
// ============================================================================
// Module   : wb_trap_prio
// Purpose  : Combinational priority encoder for retiring-instruction
//            exceptions. Priority IAF > II > IAM > ECALL > EBREAK.
// Ports    : iaf_i, ii_i, iam_i, ecall_i, ebreak_i - exception flags
//            info_o - {is_trap, cause, mtval_addr}
// Revision : 1.0 - initial release
// ============================================================================
module wb_trap_prio
  import wb_redirect_ctrl_pkg::*;
(
  input  logic       iaf_i,
  input  logic       ii_i,
  input  logic       iam_i,
  input  logic       ecall_i,
  input  logic       ebreak_i,
  output trap_info_t info_o
);

  always_comb begin
    info_o = '0;
    if (iaf_i) begin
      info_o = '{is_trap: 1'b1, cause: CAUSE_IAF, mtval_addr: 1'b1};
    end else if (ii_i) begin
      info_o = '{is_trap: 1'b1, cause: CAUSE_II, mtval_addr: 1'b0};
    end else if (iam_i) begin
      info_o = '{is_trap: 1'b1, cause: CAUSE_IAM, mtval_addr: 1'b1};
    end else if (ecall_i) begin
      info_o = '{is_trap: 1'b1, cause: CAUSE_ECALL_M, mtval_addr: 1'b0};
    end else if (ebreak_i) begin
      info_o = '{is_trap: 1'b1, cause: CAUSE_BKPT, mtval_addr: 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wb_redirect_ctrl
// Purpose  : Writeback-side fetch redirect source. Classifies the retiring
//            instruction (trap / MRET / taken branch), registers the PC-mux
//            select and target, raises FLUSH for FLUSH_CYCLES cycles and
//            strobes the machine trap CSR writes.
// Ports    : CLK   - clock
//            RESET - asynchronous active-high reset
//            bus   - wb_redirect_ctrl_if.slave (status in, redirect/CSR out)
// Revision : 1.0 - initial release
// ============================================================================
module wb_redirect_ctrl
  import wb_redirect_ctrl_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  wb_redirect_ctrl_if.slave   bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  logic [1:0]      state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [1:0]      pc_mux_q,  pc_mux_d;
  logic [XLEN-1:0] target_q,  target_d;
  logic            flush_q,   flush_d;
  logic            trap_we_q, trap_we_d;
  logic [XLEN-1:0] mepc_q,    mepc_d;
  logic [XLEN-1:0] mcause_q,  mcause_d;
  logic [XLEN-1:0] mtval_q,   mtval_d;

  trap_info_t      w_trap;
  logic [XLEN-1:0] w_vec;
  logic [XLEN-1:0] w_fault_addr;

  wb_trap_prio u_prio (
    .iaf_i    (bus.WB_IAF),
    .ii_i     (bus.WB_II),
    .iam_i    (bus.WB_IAM),
    .ecall_i  (bus.WB_ECALL),
    .ebreak_i (bus.WB_EBREAK),
    .info_o   (w_trap)
  );

  // Direct-mode vector: mode bits cleared.
  assign w_vec        = bus.DE_MTVEC & ~XLEN'(3);
  // A fetch fault on a taken branch/jump faulted at the target, not the PC.
  assign w_fault_addr = bus.WB_BR_TAKEN ? bus.WB_BR_TARGET : bus.WB_PC;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_mux_d  = PCM_SEQ;
    target_d  = target_q;
    flush_d   = 1'b0;
    trap_we_d = 1'b0;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    mtval_d   = mtval_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.WB_VALID) begin
          if (w_trap.is_trap) begin
            pc_mux_d  = PCM_TRAP;
            target_d  = w_vec;
            trap_we_d = 1'b1;
            mepc_d    = bus.WB_PC;
            mcause_d  = XLEN'(w_trap.cause);
            mtval_d   = w_trap.mtval_addr ? w_fault_addr : '0;
            flush_d   = 1'b1;
            state_d   = ST_REDIRECT;
          end else if (bus.WB_MRET) begin
            pc_mux_d  = PCM_MRET;
            target_d  = bus.CSR_MEPC;
            flush_d   = 1'b1;
            state_d   = ST_REDIRECT;
          end else if (bus.WB_BR_TAKEN) begin
            pc_mux_d  = PCM_BR;
            target_d  = bus.WB_BR_TARGET;
            flush_d   = 1'b1;
            state_d   = ST_REDIRECT;
          end
        end
      end
      ST_REDIRECT: begin
        if (FLUSH_CYCLES <= 1) begin
          state_d = ST_IDLE;
        end else begin
          // Counter holds the FLUSHING cycles still to come, this one included.
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          flush_d = 1'b1;
          state_d = ST_FLUSHING;
        end
      end
      ST_FLUSHING: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pc_mux_q  <= PCM_SEQ;
      target_q  <= '0;
      flush_q   <= 1'b0;
      trap_we_q <= 1'b0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mtval_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_mux_q  <= pc_mux_d;
      target_q  <= target_d;
      flush_q   <= flush_d;
      trap_we_q <= trap_we_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      mtval_q   <= mtval_d;
    end
  end

  assign bus.WB_PC_MUX     = pc_mux_q;
  assign bus.WB_BR_JMP_PC  = target_q;
  assign bus.FLUSH         = flush_q;
  assign bus.CSR_TRAP_WE   = trap_we_q;
  assign bus.CSR_MEPC_WD   = mepc_q;
  assign bus.CSR_MCAUSE_WD = mcause_q;
  assign bus.CSR_MTVAL_WD  = mtval_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_redirect_ctrl
// Purpose  : Directed self-checking bench for wb_redirect_ctrl with a
//            scoreboard of expected redirects.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_redirect_ctrl;

  localparam int XLEN  = 64;
  localparam int FLUSH = 3;

  typedef struct {
    logic        valid;
    logic [1:0]  mux;
    logic [63:0] tgt;
    logic        we;
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [63:0] mtval;
  } exp_t;

  logic CLK;
  logic RESET;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  wb_redirect_ctrl_if #(.XLEN(XLEN)) bus ();

  wb_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of a retiring instruction seen in IDLE.
  function automatic exp_t model(input logic [63:0] pc, input logic br, input logic [63:0] tgt,
                                 input logic iam, input logic iaf, input logic ii,
                                 input logic ec, input logic eb, input logic mret,
                                 input logic [63:0] mtvec, input logic [63:0] mepc);
    exp_t e;
    e = '{valid: 1'b0, mux: 2'b00, tgt: 64'h0, we: 1'b0, mepc: 64'h0, mcause: 64'h0, mtval: 64'h0};
    if (iaf || ii || iam || ec || eb) begin
      e.valid = 1'b1;
      e.mux   = 2'b10;
      e.tgt   = {mtvec[63:2], 2'b00};
      e.we    = 1'b1;
      e.mepc  = pc;
      if (iaf) begin
        e.mcause = 64'd1;
        e.mtval  = br ? tgt : pc;
      end else if (ii) begin
        e.mcause = 64'd2;
      end else if (iam) begin
        e.mcause = 64'd0;
        e.mtval  = br ? tgt : pc;
      end else if (ec) begin
        e.mcause = 64'd11;
      end else begin
        e.mcause = 64'd3;
      end
    end else if (mret) begin
      e.valid = 1'b1;
      e.mux   = 2'b11;
      e.tgt   = mepc;
    end else if (br) begin
      e.valid = 1'b1;
      e.mux   = 2'b01;
      e.tgt   = tgt;
    end
    return e;
  endfunction

  task automatic clear_inputs();
    bus.WB_VALID     = 1'b0;
    bus.WB_PC        = '0;
    bus.WB_BR_TAKEN  = 1'b0;
    bus.WB_BR_TARGET = '0;
    bus.WB_IAM       = 1'b0;
    bus.WB_IAF       = 1'b0;
    bus.WB_II        = 1'b0;
    bus.WB_ECALL     = 1'b0;
    bus.WB_EBREAK    = 1'b0;
    bus.WB_MRET      = 1'b0;
  endtask

  // Drive one retiring instruction; enqueue its expected redirect if any.
  task automatic send(input logic [63:0] pc, input logic br, input logic [63:0] tgt,
                      input logic iam, input logic iaf, input logic ii,
                      input logic ec, input logic eb, input logic mret, input bit push);
    exp_t e;
    bus.WB_VALID     = 1'b1;
    bus.WB_PC        = pc;
    bus.WB_BR_TAKEN  = br;
    bus.WB_BR_TARGET = tgt;
    bus.WB_IAM       = iam;
    bus.WB_IAF       = iaf;
    bus.WB_II        = ii;
    bus.WB_ECALL     = ec;
    bus.WB_EBREAK    = eb;
    bus.WB_MRET      = mret;
    e = model(pc, br, tgt, iam, iaf, ii, ec, eb, mret, bus.DE_MTVEC, bus.CSR_MEPC);
    if (push && e.valid) sb.push_back(e);
  endtask

  // Wait for the redirect, compare against the scoreboard head and follow
  // the flush window. If squash is set, a taken branch to sq_tgt is kept on
  // the bus throughout the window; it must not redirect until IDLE.
  task automatic expect_redirect(input string tag, input bit squash, input logic [63:0] sq_tgt);
    exp_t e;
    int   waited;
    bit   seen;
    waited = 0;
    seen   = 1'b0;
    @(posedge CLK);
    #1;
    clear_inputs();
    if (squash) send(64'h0, 1'b1, sq_tgt, 0, 0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge CLK);
      waited++;
      if (bus.WB_PC_MUX !== 2'b00) seen = 1'b1;
    end
    check({tag, "_latency"}, 64'(waited), 64'd1);
    check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_pc_mux"}, 64'(bus.WB_PC_MUX), 64'(e.mux));
      check({tag, "_target"}, bus.WB_BR_JMP_PC, e.tgt);
      check({tag, "_trap_we"}, 64'(bus.CSR_TRAP_WE), 64'(e.we));
      check({tag, "_flush0"}, 64'(bus.FLUSH), 64'd1);
      if (e.we) begin
        check({tag, "_mepc_wd"}, bus.CSR_MEPC_WD, e.mepc);
        check({tag, "_mcause_wd"}, bus.CSR_MCAUSE_WD, e.mcause);
        check({tag, "_mtval_wd"}, bus.CSR_MTVAL_WD, e.mtval);
      end
      for (int k = 1; k < FLUSH; k++) begin
        @(negedge CLK);
        check({tag, "_flush_hi"}, 64'(bus.FLUSH), 64'd1);
        check({tag, "_flush_mux"}, 64'(bus.WB_PC_MUX), 64'd0);
        check({tag, "_flush_we"}, 64'(bus.CSR_TRAP_WE), 64'd0);
        check({tag, "_tgt_hold"}, bus.WB_BR_JMP_PC, e.tgt);
      end
      @(negedge CLK);
      check({tag, "_flush_end"}, 64'(bus.FLUSH), 64'd0);
      check({tag, "_idle_mux"}, 64'(bus.WB_PC_MUX), 64'd0);
    end
  endtask

  initial begin
    clear_inputs();
    bus.DE_MTVEC = 64'h8003;
    bus.CSR_MEPC = 64'h2008;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_pc_mux", 64'(bus.WB_PC_MUX), 64'd0);
    check("rst_target", bus.WB_BR_JMP_PC, 64'd0);
    check("rst_flush", 64'(bus.FLUSH), 64'd0);
    check("rst_trap_we", 64'(bus.CSR_TRAP_WE), 64'd0);
    check("rst_mcause", bus.CSR_MCAUSE_WD, 64'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Branch redirect
    send(64'h0100, 1'b1, 64'h1000, 0, 0, 0, 0, 0, 0, 1'b1);
    expect_redirect("branch", 1'b0, 64'h0);

    // Illegal instruction
    send(64'h2004, 1'b0, 64'h0, 0, 0, 1'b1, 0, 0, 0, 1'b1);
    expect_redirect("illegal", 1'b0, 64'h0);

    // IAF beats II and branch; mtval from branch target
    send(64'h3000, 1'b1, 64'h3002, 0, 1'b1, 1'b1, 0, 0, 0, 1'b1);
    expect_redirect("prio_iaf", 1'b0, 64'h0);

    // IAM without branch: mtval is the PC
    send(64'h4002, 1'b0, 64'h0, 1'b1, 0, 0, 0, 0, 0, 1'b1);
    expect_redirect("iam", 1'b0, 64'h0);

    // EBREAK
    send(64'h4100, 1'b0, 64'h0, 0, 0, 0, 0, 1'b1, 0, 1'b1);
    expect_redirect("ebreak", 1'b0, 64'h0);

    // ECALL with MRET and branch: trap wins
    send(64'h4200, 1'b1, 64'h9999, 0, 0, 0, 1'b1, 0, 1'b1, 1'b1);
    expect_redirect("ecall_prio", 1'b0, 64'h0);

    // MRET
    send(64'h4300, 1'b0, 64'h0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    expect_redirect("mret", 1'b0, 64'h0);

    // Retiring instruction with no event: no redirect, target holds
    send(64'h4400, 1'b0, 64'h5000, 0, 0, 0, 0, 0, 0, 1'b1);
    @(posedge CLK);
    #1;
    clear_inputs();
    @(negedge CLK);
    check("noevt_mux", 64'(bus.WB_PC_MUX), 64'd0);
    check("noevt_flush", 64'(bus.FLUSH), 64'd0);
    check("noevt_tgt_hold", bus.WB_BR_JMP_PC, 64'h2008);

    // Squash window: branch to 0x5555 held during flush, accepted after
    send(64'h4500, 1'b1, 64'h1234, 0, 0, 0, 0, 0, 0, 1'b1);
    expect_redirect("squash_first", 1'b1, 64'h5555);
    sb.push_back(model(64'h0, 1'b1, 64'h5555, 0, 0, 0, 0, 0, 0, bus.DE_MTVEC, bus.CSR_MEPC));
    expect_redirect("squash_after", 1'b0, 64'h0);

    // Async reset in FLUSHING
    send(64'h4600, 1'b1, 64'h6000, 0, 0, 0, 0, 0, 0, 1'b0);
    @(posedge CLK);
    #1;
    clear_inputs();
    @(negedge CLK);
    check("ar_redirect_mux", 64'(bus.WB_PC_MUX), 64'd1);
    @(negedge CLK);
    check("ar_flushing", 64'(bus.FLUSH), 64'd1);
    RESET = 1'b1;
    #1;
    check("ar_flush", 64'(bus.FLUSH), 64'd0);
    check("ar_pc_mux", 64'(bus.WB_PC_MUX), 64'd0);
    check("ar_target", bus.WB_BR_JMP_PC, 64'd0);
    check("ar_mcause", bus.CSR_MCAUSE_WD, 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("ar_idle_flush", 64'(bus.FLUSH), 64'd0);
    send(64'h7000, 1'b0, 64'h0, 0, 0, 0, 1'b1, 0, 0, 1'b1);
    expect_redirect("ecall_after_rst", 1'b0, 64'h0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_redirect_ctrl.md
Name: wb_redirect_ctrl

Overview:
Writeback-side source of the fetch redirect interface. It consumes retiring-instruction status (branch/jump resolution, fetch/decode exceptions, ECALL/EBREAK, MRET) and produces the registered PC-mux select and target that fetch consumes, together with pipeline flush and machine-mode trap CSR write strobes. It sits between the memory/writeback pipeline latch and the fetch stage and CSR file.

Parameters:
XLEN, 64, datapath/PC width
FLUSH_CYCLES, 3, cycles FLUSH stays high after a redirect (pipeline depth ahead of WB)

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous active-high reset
WB_VALID  in  1  instruction retiring this cycle
WB_PC  in  XLEN  PC of retiring instruction
WB_BR_TAKEN  in  1  branch taken or JAL/JALR
WB_BR_TARGET  in  XLEN  resolved branch/jump target
WB_IAM  in  1  instruction-address-misaligned flag carried from fetch
WB_IAF  in  1  instruction-access-fault flag carried from fetch
WB_II  in  1  illegal-instruction flag from decode
WB_ECALL  in  1  ECALL retiring
WB_EBREAK  in  1  EBREAK retiring
WB_MRET  in  1  MRET retiring
DE_MTVEC  in  XLEN  current mtvec (direct mode only)
CSR_MEPC  in  XLEN  current mepc
WB_PC_MUX  out  2  00 sequential, 01 branch/jump, 10 trap vector, 11 mepc return
WB_BR_JMP_PC  out  XLEN  redirect target, valid when WB_PC_MUX != 00
FLUSH  out  1  squash all younger in-flight instructions
CSR_TRAP_WE  out  1  one-cycle strobe: write mepc/mcause/mtval
CSR_MEPC_WD  out  XLEN  value for mepc
CSR_MCAUSE_WD  out  XLEN  value for mcause
CSR_MTVAL_WD  out  XLEN  value for mtval

Behaviour:
- Reset (async, RESET=1): state IDLE, WB_PC_MUX=00, WB_BR_JMP_PC=0, FLUSH=0, CSR_TRAP_WE=0, all CSR_*_WD=0, flush counter=0. Deassertion takes effect on the next CLK edge.
- States: IDLE, REDIRECT, FLUSHING.
- IDLE: on a rising edge with WB_VALID=1, classify the event by priority: IAF > II > IAM > ECALL > EBREAK (trap) > MRET > BR_TAKEN > none.
  - Trap: next cycle WB_PC_MUX=10, WB_BR_JMP_PC={DE_MTVEC[XLEN-1:2],2'b00}, CSR_TRAP_WE=1, CSR_MEPC_WD=WB_PC.
  - CSR_MCAUSE_WD codes: IAF=1, II=2, IAM=0, EBREAK=3, ECALL=11 (interrupt bit 0).
  - CSR_MTVAL_WD: IAF/IAM use WB_BR_TARGET when WB_BR_TAKEN=1, else WB_PC; all other causes 0.
  - MRET (no trap): WB_PC_MUX=11, WB_BR_JMP_PC=CSR_MEPC.
  - Branch (no trap, no MRET): WB_PC_MUX=01, WB_BR_JMP_PC=WB_BR_TARGET.
  - Any redirect moves to REDIRECT. No event: stay IDLE, outputs 00/0.
- Latency: exactly one cycle from the sampled WB_VALID edge to the redirect outputs.
- REDIRECT (one cycle): outputs as above, FLUSH=1; load counter=FLUSH_CYCLES-1; go to FLUSHING, or to IDLE if FLUSH_CYCLES=1.
- FLUSHING: WB_PC_MUX=00, CSR_TRAP_WE=0, FLUSH=1; decrement the counter; go to IDLE when the counter reaches 0. Total FLUSH high = FLUSH_CYCLES cycles.
- WB_VALID is ignored in REDIRECT and FLUSHING (those instructions are squashed).
- CSR_TRAP_WE is high for exactly one cycle per trap. WB_BR_JMP_PC holds its last value while WB_PC_MUX=00.
- Multiple flags in one cycle: only the highest priority is acted on. MRET or branch together with any trap flag: trap wins.
- Reset mid-FLUSHING: outputs return to reset values immediately and asynchronously.

Decomposition:
- Shared package/header: PC_MUX encodings (PCM_SEQ=2'b00, PCM_BR=2'b01, PCM_TRAP=2'b10, PCM_MRET=2'b11), mcause constants (CAUSE_IAM=0, CAUSE_IAF=1, CAUSE_II=2, CAUSE_BKPT=3, CAUSE_ECALL_M=11), FSM state encodings.
- One sub-module: wb_trap_prio, a combinational priority encoder that maps the flags to {is_trap, cause, mtval_sel}.

Test Plan:
1. Branch redirect: WB_VALID=1, WB_BR_TAKEN=1, WB_BR_TARGET=0x1000 -> next cycle WB_PC_MUX=01, WB_BR_JMP_PC=0x1000; FLUSH high for 3 cycles; CSR_TRAP_WE stays 0.
2. Illegal instruction: WB_PC=0x2004, WB_II=1, DE_MTVEC=0x8003 -> WB_PC_MUX=10, target 0x8000; CSR_TRAP_WE=1 for 1 cycle; MEPC_WD=0x2004, MCAUSE_WD=2, MTVAL_WD=0.
3. Priority: IAF=1, II=1, BR_TAKEN=1, WB_BR_TARGET=0x3002 -> MCAUSE_WD=1, MTVAL_WD=0x3002, WB_PC_MUX=10.
4. MRET: CSR_MEPC=0x2008, WB_MRET=1 -> WB_PC_MUX=11, WB_BR_JMP_PC=0x2008, no CSR write.
5. Squash window: a second branch with WB_VALID=1 in each of the 3 FLUSH cycles -> ignored; the next redirect is accepted only after return to IDLE.
6. Async reset during FLUSHING: assert RESET mid-cycle -> FLUSH=0, WB_PC_MUX=00 before the next CLK edge; after release, an ECALL yields MCAUSE_WD=11.
